snitch_icache_refill_responder: RTL and testbench
=================================================

Name: snitch_icache_refill_responder

Overview:
- Responder end of the L0 refill interface. Accepts line-refill requests from the L0 caches, tracks them in a small pending-miss table and issues one downstream memory request per table entry.
- Returns each line to the L0 side with the merged L0 ID mask of every requester waiting on that line.
- Sits between the L0 refill arbiter and the shared L1/memory refill port.

Parameters:
- FETCH_AW, 32, address width in bits.
- LINE_WIDTH, 128, cache line width in bits (power of two, at least 32).
- ID_WIDTH, 4, width of the L0 ID bitmask (one bit per L0 and request kind).
- PENDING_COUNT, 4, number of pending-miss table entries (power of two, at least 2).
- LINE_ALIGN, $clog2(LINE_WIDTH/8), derived; byte offset bits within a line.
- MEM_ID_WIDTH, $clog2(PENDING_COUNT), derived; downstream transaction ID width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_req_addr_i  in  FETCH_AW  refill address from L0 (any alignment)
- in_req_id_i  in  ID_WIDTH  requester ID bitmask
- in_req_valid_i  in  1  request valid
- in_req_ready_o  out  1  request accepted
- in_rsp_data_o  out  LINE_WIDTH  line data
- in_rsp_error_o  out  1  line fetched with error
- in_rsp_id_o  out  ID_WIDTH  merged ID bitmask of all waiting requesters
- in_rsp_valid_o  out  1  response valid
- in_rsp_ready_i  in  1  response accepted
- mem_req_addr_o  out  FETCH_AW  line-aligned downstream address
- mem_req_id_o  out  MEM_ID_WIDTH  table index of the request
- mem_req_valid_o  out  1  downstream request valid
- mem_req_ready_i  in  1  downstream request accepted
- mem_rsp_data_i  in  LINE_WIDTH  downstream line data
- mem_rsp_error_i  in  1  downstream error
- mem_rsp_id_i  in  MEM_ID_WIDTH  table index being answered
- mem_rsp_valid_i  in  1  downstream response valid
- mem_rsp_ready_o  out  1  downstream response accepted

Behaviour:
- Table entry fields: vld, issued, addr (line-aligned: addr >> LINE_ALIGN << LINE_ALIGN), idmask.
- Reset: all entries cleared (vld=0, issued=0). All valid outputs 0. mem_rsp_ready_o=1. Data, ID and address outputs 0.
- Merge candidate: a vld entry whose addr equals the aligned in_req_addr_i and which is not retiring this cycle.
- Handshake on in_req_valid_i & in_req_ready_o:
  - Candidate exists (coalescing compiled in, see Optional Feature): idmask |= in_req_id_i. No new entry, no new mem request.
  - Otherwise: allocate the lowest-index entry that was free at cycle start; set vld=1, issued=0, addr, idmask=in_req_id_i.
- in_req_ready_o = merge candidate exists OR a free entry exists. Combinational; does not depend on in_req_valid_i.
- Table full and no merge candidate: in_req_ready_o=0. A slot retiring this cycle becomes allocatable only from the next cycle.
- Issuer:
  - mem_req_valid_o=1 when any entry has vld & ~issued. Selects the lowest such index; mem_req_id_o = that index, mem_req_addr_o = its addr.
  - On mem_req handshake, that entry's issued=1.
  - Selection is held stable while mem_req_valid_o & ~mem_req_ready_i. A newly allocated lower-index entry must not preempt a stalled request; hold the selection in a register.
  - Latency: allocation in cycle N -> mem_req_valid_o at earliest in cycle N+1.
- Response register (one-deep):
  - mem_rsp_ready_o = ~in_rsp_valid_o | in_rsp_ready_i.
  - On mem_rsp handshake: capture data and error, in_rsp_id_o = idmask[mem_rsp_id_i] (including any merge arriving in the same cycle), set in_rsp_valid_o=1, retire the entry (vld=0, issued=0).
  - Latency is 1 cycle from mem_rsp handshake to in_rsp_valid_o.
  - Back-to-back responses at full throughput when in_rsp_ready_i=1.
- in_rsp_* held stable while in_rsp_valid_o & ~in_rsp_ready_i.
- Error: mem_rsp_error_i is passed through unchanged. The entry is retired normally and is not retried.
- A mem response addressing an entry that is not vld & issued is a protocol violation; flag it with an assertion.
- Assertions:
  - mem_req and in_rsp stability.
  - No two vld entries with equal addr (coalescing on only).

Optional Feature:
- Macro: SNITCH_ICACHE_REFILL_COALESCE_EN.
- Defined: merging as above. Duplicate in-flight lines produce a single mem request and a single in_rsp carrying OR'd IDs.
- Not defined:
  - No merge candidates.
  - Every accepted request allocates its own entry and mem request.
  - in_req_ready_o = free entry exists.
  - in_rsp_id_o equals the single requester's ID.

Test Plan:
- Single miss: req addr 0x1004, id 0b0001 -> mem_req addr 0x1000, id 0, one cycle later. mem_rsp id 0, data D -> in_rsp data D, id 0b0001, error 0, next cycle.
- Coalesce (macro on): req 0x2000 id 0b0001, then req 0x2008 id 0b0100 before the mem response -> exactly one mem_req, and in_rsp id 0b0101. Macro off -> two mem_reqs, two in_rsps with ids 0b0001 and 0b0100.
- Full table: PENDING_COUNT distinct lines, mem_rsp withheld -> in_req_ready_o=0 for a fifth distinct line. A mem_rsp for id 2 -> slot 2 reallocated one cycle later.
- Backpressure: mem_req_ready_i=0 for 5 cycles, then a new allocation at a lower index -> mem_req addr/id stable throughout. in_rsp_ready_i=0 -> mem_rsp_ready_o=0, in_rsp stable.
- Out-of-order and error: issue ids 0,1,2; respond 2,0,1 with error on id 0 -> in_rsp order matches and carries error=1 only for id 0's line.
- Reset mid-operation: assert rst_ni low with 3 entries pending -> all outputs 0 and table empty. After release, a new request allocates entry 0.

Source files
------------

// File: rtl/snitch_icache_refill_responder.sv
// Responder for L0 instruction-cache line refills: pending-miss table, downstream issuer, one-deep response register.
// Define SNITCH_ICACHE_REFILL_COALESCE_EN to merge requests hitting a line that is already in flight.
module snitch_icache_refill_responder #(
    parameter int unsigned FETCH_AW      = 32,
    parameter int unsigned LINE_WIDTH    = 128,
    parameter int unsigned ID_WIDTH      = 4,
    parameter int unsigned PENDING_COUNT = 4,
    parameter int unsigned LINE_ALIGN    = $clog2(LINE_WIDTH / 8),
    parameter int unsigned MEM_ID_WIDTH  = $clog2(PENDING_COUNT)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [FETCH_AW-1:0]     in_req_addr_i,
    input  logic [ID_WIDTH-1:0]     in_req_id_i,
    input  logic                    in_req_valid_i,
    output logic                    in_req_ready_o,
    output logic [LINE_WIDTH-1:0]   in_rsp_data_o,
    output logic                    in_rsp_error_o,
    output logic [ID_WIDTH-1:0]     in_rsp_id_o,
    output logic                    in_rsp_valid_o,
    input  logic                    in_rsp_ready_i,
    output logic [FETCH_AW-1:0]     mem_req_addr_o,
    output logic [MEM_ID_WIDTH-1:0] mem_req_id_o,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    input  logic [LINE_WIDTH-1:0]   mem_rsp_data_i,
    input  logic                    mem_rsp_error_i,
    input  logic [MEM_ID_WIDTH-1:0] mem_rsp_id_i,
    input  logic                    mem_rsp_valid_i,
    output logic                    mem_rsp_ready_o
);

    logic [PENDING_COUNT-1:0] vld_q, issued_q;
    logic [FETCH_AW-1:0]      addr_q   [PENDING_COUNT];
    logic [ID_WIDTH-1:0]      idmask_q [PENDING_COUNT];

    logic [FETCH_AW-1:0] req_addr_aligned;
    logic                unused_addr_bits;
    assign req_addr_aligned = {in_req_addr_i[FETCH_AW-1:LINE_ALIGN], {LINE_ALIGN{1'b0}}};
    assign unused_addr_bits = ^in_req_addr_i[LINE_ALIGN-1:0];

    logic in_req_hs, mem_req_hs, mem_rsp_hs;
    logic merge_hit, free_any, pend_any;
    logic [MEM_ID_WIDTH-1:0] merge_idx, free_idx, pend_idx;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        pend_any  = 1'b0;
        pend_idx  = '0;
        for (int i = int'(PENDING_COUNT) - 1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                free_any = 1'b1;
                free_idx = MEM_ID_WIDTH'(i);
            end
            if (vld_q[i] && !issued_q[i]) begin
                pend_any = 1'b1;
                pend_idx = MEM_ID_WIDTH'(i);
            end
`ifdef SNITCH_ICACHE_REFILL_COALESCE_EN
            if (vld_q[i] && (addr_q[i] == req_addr_aligned) &&
                !(mem_rsp_hs && (mem_rsp_id_i == MEM_ID_WIDTH'(i)))) begin
                merge_hit = 1'b1;
                merge_idx = MEM_ID_WIDTH'(i);
            end
`endif
        end
    end

    assign in_req_ready_o = merge_hit | free_any;
    assign in_req_hs      = in_req_valid_i & in_req_ready_o;

    // A stalled downstream request keeps its entry even if a lower index becomes pending.
    logic                    sel_lock_q;
    logic [MEM_ID_WIDTH-1:0] sel_q, sel_idx;

    assign sel_idx         = sel_lock_q ? sel_q : pend_idx;
    assign mem_req_valid_o = sel_lock_q | pend_any;
    assign mem_req_id_o    = mem_req_valid_o ? sel_idx : '0;
    assign mem_req_addr_o  = mem_req_valid_o ? addr_q[sel_idx] : '0;
    assign mem_req_hs      = mem_req_valid_o & mem_req_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_lock_q <= 1'b0;
            sel_q      <= '0;
        end else if (mem_req_valid_o && !mem_req_ready_i) begin
            sel_lock_q <= 1'b1;
            sel_q      <= sel_idx;
        end else begin
            sel_lock_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q    <= '0;
            issued_q <= '0;
            for (int i = 0; i < int'(PENDING_COUNT); i++) begin
                addr_q[i]   <= '0;
                idmask_q[i] <= '0;
            end
        end else begin
            if (mem_req_hs) begin
                issued_q[sel_idx] <= 1'b1;
            end
            if (in_req_hs) begin
                if (merge_hit) begin
                    idmask_q[merge_idx] <= idmask_q[merge_idx] | in_req_id_i;
                end else begin
                    vld_q[free_idx]    <= 1'b1;
                    issued_q[free_idx] <= 1'b0;
                    addr_q[free_idx]   <= req_addr_aligned;
                    idmask_q[free_idx] <= in_req_id_i;
                end
            end
            if (mem_rsp_hs) begin
                vld_q[mem_rsp_id_i]    <= 1'b0;
                issued_q[mem_rsp_id_i] <= 1'b0;
            end
        end
    end

    logic                  rsp_valid_q, rsp_error_q;
    logic [LINE_WIDTH-1:0] rsp_data_q;
    logic [ID_WIDTH-1:0]   rsp_id_q;

    assign mem_rsp_ready_o = ~rsp_valid_q | in_rsp_ready_i;
    assign mem_rsp_hs      = mem_rsp_valid_i & mem_rsp_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else if (mem_rsp_hs) begin
            rsp_valid_q <= 1'b1;
            rsp_error_q <= mem_rsp_error_i;
            rsp_data_q  <= mem_rsp_data_i;
            rsp_id_q    <= idmask_q[mem_rsp_id_i];
        end else if (in_rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign in_rsp_valid_o = rsp_valid_q;
    assign in_rsp_error_o = rsp_error_q;
    assign in_rsp_data_o  = rsp_data_q;
    assign in_rsp_id_o    = rsp_id_q;

`ifndef SYNTHESIS
    a_mem_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_req_valid_o && !mem_req_ready_i |=>
            mem_req_valid_o && $stable(mem_req_addr_o) && $stable(mem_req_id_o));

    a_in_rsp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        in_rsp_valid_o && !in_rsp_ready_i |=>
            in_rsp_valid_o && $stable(in_rsp_data_o) && $stable(in_rsp_id_o) && $stable(in_rsp_error_o));

    a_mem_rsp_known_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rsp_hs |-> vld_q[mem_rsp_id_i] && issued_q[mem_rsp_id_i]);

`ifdef SNITCH_ICACHE_REFILL_COALESCE_EN
    logic dup_found;
    always_comb begin
        dup_found = 1'b0;
        for (int i = 0; i < int'(PENDING_COUNT); i++) begin
            for (int j = i + 1; j < int'(PENDING_COUNT); j++) begin
                if (vld_q[i] && vld_q[j] && (addr_q[i] == addr_q[j])) dup_found = 1'b1;
            end
        end
    end

    a_no_dup_lines: assert property (@(posedge clk_i) disable iff (!rst_ni) !dup_found);
`endif
`endif

endmodule

// File: tb/tb_snitch_icache_refill_responder.sv
// Directed bench for snitch_icache_refill_responder: vector table of single misses plus multi-cycle sequences.
module tb_snitch_icache_refill_responder;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [31:0]  in_req_addr_i = '0;
    logic [3:0]   in_req_id_i = '0;
    logic         in_req_valid_i = 1'b0;
    logic         in_req_ready_o;
    logic [127:0] in_rsp_data_o;
    logic         in_rsp_error_o;
    logic [3:0]   in_rsp_id_o;
    logic         in_rsp_valid_o;
    logic         in_rsp_ready_i = 1'b1;
    logic [31:0]  mem_req_addr_o;
    logic [1:0]   mem_req_id_o;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i = 1'b1;
    logic [127:0] mem_rsp_data_i = '0;
    logic         mem_rsp_error_i = 1'b0;
    logic [1:0]   mem_rsp_id_i = '0;
    logic         mem_rsp_valid_i = 1'b0;
    logic         mem_rsp_ready_o;

    snitch_icache_refill_responder dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .in_req_addr_i   (in_req_addr_i),
        .in_req_id_i     (in_req_id_i),
        .in_req_valid_i  (in_req_valid_i),
        .in_req_ready_o  (in_req_ready_o),
        .in_rsp_data_o   (in_rsp_data_o),
        .in_rsp_error_o  (in_rsp_error_o),
        .in_rsp_id_o     (in_rsp_id_o),
        .in_rsp_valid_o  (in_rsp_valid_o),
        .in_rsp_ready_i  (in_rsp_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_id_o    (mem_req_id_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .mem_rsp_error_i (mem_rsp_error_i),
        .mem_rsp_id_i    (mem_rsp_id_i),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_ready_o (mem_rsp_ready_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  id;
    } memtxn_t;

    typedef struct packed {
        logic [127:0] data;
        logic         err;
        logic [3:0]   id;
    } rsptxn_t;

    memtxn_t memq[$];
    rsptxn_t rspq[$];

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (mem_req_valid_o && mem_req_ready_i) memq.push_back({mem_req_addr_o, mem_req_id_o});
            if (in_rsp_valid_o && in_rsp_ready_i) rspq.push_back({in_rsp_data_o, in_rsp_error_o, in_rsp_id_o});
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_req(input logic [31:0] addr, input logic [3:0] id);
        int i;
        in_req_addr_i  = addr;
        in_req_id_i    = id;
        in_req_valid_i = 1'b1;
        #1;
        for (i = 0; i < 50 && !in_req_ready_o; i++) step();
        if (!in_req_ready_o) chk("req_accept_timeout", 128'(in_req_ready_o), 128'(1));
        step();
        in_req_valid_i = 1'b0;
    endtask

    task automatic mem_respond(input logic [1:0] id, input logic [127:0] d, input logic e);
        int i;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_id_i    = id;
        mem_rsp_data_i  = d;
        mem_rsp_error_i = e;
        #1;
        for (i = 0; i < 50 && !mem_rsp_ready_o; i++) step();
        if (!mem_rsp_ready_o) chk("mem_rsp_timeout", 128'(mem_rsp_ready_o), 128'(1));
        step();
        mem_rsp_valid_i = 1'b0;
    endtask

    task automatic wait_memq(input int n);
        for (int i = 0; i < 50 && memq.size() < n; i++) step();
        chk("memq_count", 128'(memq.size()), 128'(n));
    endtask

    task automatic wait_rspq(input int n);
        for (int i = 0; i < 50 && rspq.size() < n; i++) step();
        chk("rspq_count", 128'(rspq.size()), 128'(n));
    endtask

    typedef struct {
        logic [31:0]  addr;
        logic [3:0]   id;
        logic [127:0] data;
        logic         err;
        logic [31:0]  exp_mem_addr;
        logic [3:0]   exp_rsp_id;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_1004, 4'b0001, 128'hDEAD_BEEF_0000_0001_1111_2222_3333_4444, 1'b0, 32'h0000_1000, 4'b0001};
        vecs[1] = '{32'h0000_ABCF, 4'b1000, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1, 32'h0000_ABC0, 4'b1000};
        vecs[2] = '{32'hFFFF_FFFF, 4'b0110, 128'hFFFF_0000_FFFF_0000_A5A5_5A5A_C3C3_3C3C, 1'b0, 32'hFFFF_FFF0, 4'b0110};
        vecs[3] = '{32'h8000_0010, 4'b1111, 128'h0000_0000_0000_0000_0000_0000_0000_0001, 1'b0, 32'h8000_0010, 4'b1111};

        // reset state
        #1;
        chk("rst_mem_req_valid", 128'(mem_req_valid_o), 128'(0));
        chk("rst_in_rsp_valid", 128'(in_rsp_valid_o), 128'(0));
        chk("rst_mem_rsp_ready", 128'(mem_rsp_ready_o), 128'(1));
        chk("rst_mem_req_addr", 128'(mem_req_addr_o), 128'(0));
        chk("rst_in_rsp_data", in_rsp_data_o, 128'(0));
        chk("rst_in_rsp_id", 128'(in_rsp_id_o), 128'(0));
        step();
        step();
        rst_ni = 1'b1;
        step();
        chk("idle_in_req_ready", 128'(in_req_ready_o), 128'(1));

        // single misses from the table
        for (int v = 0; v < 4; v++) begin
            send_req(vecs[v].addr, vecs[v].id);
            chk($sformatf("vec%0d_mem_valid", v), 128'(mem_req_valid_o), 128'(1));
            chk($sformatf("vec%0d_mem_addr", v), 128'(mem_req_addr_o), 128'(vecs[v].exp_mem_addr));
            chk($sformatf("vec%0d_mem_id", v), 128'(mem_req_id_o), 128'(0));
            step();
            chk($sformatf("vec%0d_mem_done", v), 128'(mem_req_valid_o), 128'(0));
            mem_respond(2'd0, vecs[v].data, vecs[v].err);
            chk($sformatf("vec%0d_rsp_valid", v), 128'(in_rsp_valid_o), 128'(1));
            chk($sformatf("vec%0d_rsp_data", v), in_rsp_data_o, vecs[v].data);
            chk($sformatf("vec%0d_rsp_id", v), 128'(in_rsp_id_o), 128'(vecs[v].exp_rsp_id));
            chk($sformatf("vec%0d_rsp_err", v), 128'(in_rsp_error_o), 128'(vecs[v].err));
            step();
            chk($sformatf("vec%0d_rsp_drop", v), 128'(in_rsp_valid_o), 128'(0));
        end

        // coalescing of two requests to the same line
        memq.delete();
        rspq.delete();
        send_req(32'h0000_2000, 4'b0001);
        send_req(32'h0000_2008, 4'b0100);
        step();
        step();
`ifdef SNITCH_ICACHE_REFILL_COALESCE_EN
        chk("coal_memq_count", 128'(memq.size()), 128'(1));
        mem_respond(2'd0, 128'hC0A1, 1'b0);
        wait_rspq(1);
        chk("coal_rsp_id", 128'(rspq[0].id), 128'(4'b0101));
        chk("coal_rsp_data", rspq[0].data, 128'hC0A1);
`else
        chk("coal_memq_count", 128'(memq.size()), 128'(2));
        chk("coal_mem0", 128'(memq[0]), 128'({32'h0000_2000, 2'd0}));
        chk("coal_mem1", 128'(memq[1]), 128'({32'h0000_2000, 2'd1}));
        mem_respond(2'd0, 128'hC0A1, 1'b0);
        mem_respond(2'd1, 128'hC0A2, 1'b0);
        wait_rspq(2);
        chk("coal_rsp0_id", 128'(rspq[0].id), 128'(4'b0001));
        chk("coal_rsp1_id", 128'(rspq[1].id), 128'(4'b0100));
        chk("coal_rsp1_data", rspq[1].data, 128'hC0A2);
`endif

        // full table, retirement frees a slot one cycle later
        memq.delete();
        for (int k = 0; k < 4; k++) send_req(32'h0000_3000 + 32'(k * 16), 4'b0001);
        wait_memq(4);
        in_req_addr_i  = 32'h0000_3040;
        in_req_id_i    = 4'b0010;
        in_req_valid_i = 1'b1;
        #1;
        chk("full_ready_low", 128'(in_req_ready_o), 128'(0));
        step();
        step();
        chk("full_ready_still_low", 128'(in_req_ready_o), 128'(0));
        mem_rsp_valid_i = 1'b1;
        mem_rsp_id_i    = 2'd2;
        mem_rsp_data_i  = 128'hF00D;
        mem_rsp_error_i = 1'b0;
        #1;
        chk("full_retire_cycle_ready", 128'(in_req_ready_o), 128'(0));
        step();
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("full_next_cycle_ready", 128'(in_req_ready_o), 128'(1));
        step();
        in_req_valid_i = 1'b0;
        chk("full_realloc_valid", 128'(mem_req_valid_o), 128'(1));
        chk("full_realloc_id", 128'(mem_req_id_o), 128'(2));
        chk("full_realloc_addr", 128'(mem_req_addr_o), 128'(32'h0000_3040));
        step();
        mem_respond(2'd0, 128'h1, 1'b0);
        mem_respond(2'd1, 128'h2, 1'b0);
        mem_respond(2'd3, 128'h3, 1'b0);
        mem_respond(2'd2, 128'h4, 1'b0);
        step();

        // downstream backpressure with a lower-index allocation behind a stalled request
        send_req(32'h0000_4000, 4'b0001);
        send_req(32'h0000_4010, 4'b0010);
        step();
        mem_req_ready_i = 1'b0;
        send_req(32'h0000_4020, 4'b0100);
        mem_respond(2'd0, 128'h5, 1'b0);
        send_req(32'h0000_4030, 4'b1000);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_valid_c%0d", c), 128'(mem_req_valid_o), 128'(1));
            chk($sformatf("bp_id_c%0d", c), 128'(mem_req_id_o), 128'(2));
            chk($sformatf("bp_addr_c%0d", c), 128'(mem_req_addr_o), 128'(32'h0000_4020));
            step();
        end
        memq.delete();
        mem_req_ready_i = 1'b1;
        wait_memq(2);
        chk("bp_issue0", 128'(memq[0]), 128'({32'h0000_4020, 2'd2}));
        chk("bp_issue1", 128'(memq[1]), 128'({32'h0000_4030, 2'd0}));

        // response backpressure then back-to-back responses
        in_rsp_ready_i  = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_id_i    = 2'd1;
        mem_rsp_data_i  = 128'hDA;
        mem_rsp_error_i = 1'b0;
        #1;
        chk("rbp_ready_empty", 128'(mem_rsp_ready_o), 128'(1));
        step();
        mem_rsp_id_i   = 2'd2;
        mem_rsp_data_i = 128'hDB;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rbp_valid_c%0d", c), 128'(in_rsp_valid_o), 128'(1));
            chk($sformatf("rbp_data_c%0d", c), in_rsp_data_o, 128'hDA);
            chk($sformatf("rbp_id_c%0d", c), 128'(in_rsp_id_o), 128'(4'b0010));
            chk($sformatf("rbp_mem_ready_c%0d", c), 128'(mem_rsp_ready_o), 128'(0));
            step();
        end
        in_rsp_ready_i = 1'b1;
        #1;
        chk("rbp_mem_ready_back", 128'(mem_rsp_ready_o), 128'(1));
        step();
        mem_rsp_id_i   = 2'd0;
        mem_rsp_data_i = 128'hDC;
        chk("b2b_data0", in_rsp_data_o, 128'hDB);
        chk("b2b_id0", 128'(in_rsp_id_o), 128'(4'b0100));
        step();
        mem_rsp_valid_i = 1'b0;
        chk("b2b_valid1", 128'(in_rsp_valid_o), 128'(1));
        chk("b2b_data1", in_rsp_data_o, 128'hDC);
        chk("b2b_id1", 128'(in_rsp_id_o), 128'(4'b1000));
        step();
        chk("b2b_drop", 128'(in_rsp_valid_o), 128'(0));

        // out-of-order responses with an error on one line
        memq.delete();
        rspq.delete();
        send_req(32'h0000_5000, 4'b0001);
        send_req(32'h0000_5010, 4'b0010);
        send_req(32'h0000_5020, 4'b0100);
        wait_memq(3);
        chk("ooo_issue_ids", 128'({memq[0].id, memq[1].id, memq[2].id}), 128'(6'b00_01_10));
        mem_respond(2'd2, 128'hA2, 1'b0);
        mem_respond(2'd0, 128'hA0, 1'b1);
        mem_respond(2'd1, 128'hA1, 1'b0);
        wait_rspq(3);
        chk("ooo_rsp0", 128'(rspq[0]), 128'({128'hA2, 1'b0, 4'b0100}));
        chk("ooo_rsp1", 128'(rspq[1]), 128'({128'hA0, 1'b1, 4'b0001}));
        chk("ooo_rsp2", 128'(rspq[2]), 128'({128'hA1, 1'b0, 4'b0010}));

        // reset while three entries are pending
        mem_req_ready_i = 1'b0;
        send_req(32'h0000_6000, 4'b0001);
        send_req(32'h0000_6010, 4'b0010);
        send_req(32'h0000_6020, 4'b0100);
        chk("rmid_pending", 128'(mem_req_valid_o), 128'(1));
        rst_ni = 1'b0;
        #1;
        chk("rmid_mem_valid", 128'(mem_req_valid_o), 128'(0));
        chk("rmid_mem_addr", 128'(mem_req_addr_o), 128'(0));
        chk("rmid_in_rsp_valid", 128'(in_rsp_valid_o), 128'(0));
        chk("rmid_in_rsp_data", in_rsp_data_o, 128'(0));
        chk("rmid_in_rsp_err", 128'(in_rsp_error_o), 128'(0));
        chk("rmid_mem_rsp_ready", 128'(mem_rsp_ready_o), 128'(1));
        step();
        step();
        rst_ni = 1'b1;
        mem_req_ready_i = 1'b1;
        step();
        memq.delete();
        send_req(32'h0000_7000, 4'b1000);
        chk("rpost_mem_valid", 128'(mem_req_valid_o), 128'(1));
        chk("rpost_mem_id", 128'(mem_req_id_o), 128'(0));
        chk("rpost_mem_addr", 128'(mem_req_addr_o), 128'(32'h0000_7000));
        for (int c = 0; c < 6; c++) step();
        chk("rpost_single_issue", 128'(memq.size()), 128'(1));
        mem_respond(2'd0, 128'h77, 1'b0);
        chk("rpost_rsp_id", 128'(in_rsp_id_o), 128'(4'b1000));
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
